// File: rtl/cfg_serial_pkg.sv
`timescale 1ns/1ps
// cfg_serial_pkg: shared definitions for the serial configuration master.
//   - FSM state encoding used by cfg_serial_master
//   - clog2_min1(): counter-width helper (never returns less than 1 bit)
package cfg_serial_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_TGT  = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_WAIT_RDY = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    // Bits needed to count 0..value-1; at least 1 so degenerate sizes still elaborate.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cfg_sclk_gen.sv
`timescale 1ns/1ps
// cfg_sclk_gen: serial clock phase generator.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : high while the master is shifting
//   sclk       : registered serial clock, SCLK_DIV cycles low then SCLK_DIV high
//   bit_start  : strobe in the cycle whose edge starts a bit (low phase begins)
//   bit_end    : strobe in the cycle whose edge ends a bit (last high cycle)
// The phase counter restarts at zero whenever en is low, so each shift
// sequence begins with a full low phase.
module cfg_sclk_gen
    import cfg_serial_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic bit_start,
    output logic bit_end
);
    localparam int unsigned     PH_W    = clog2_min1(2 * SCLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(SCLK_DIV);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    logic [PH_W-1:0] ph_cnt_r;
    logic            sclk_r;

    // Phase counter over one full sclk period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt_r <= {PH_W{1'b0}};
        end else if (!en) begin
            ph_cnt_r <= {PH_W{1'b0}};
        end else if (ph_cnt_r == PH_LAST) begin
            ph_cnt_r <= {PH_W{1'b0}};
        end else begin
            ph_cnt_r <= ph_cnt_r + PH_ONE;
        end
    end

    // Registered sclk: high for the second half of the period, low when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_r <= 1'b0;
        end else if (en) begin
            sclk_r <= (ph_cnt_r >= PH_HIGH);
        end else begin
            sclk_r <= 1'b0;
        end
    end

    assign sclk      = sclk_r;
    assign bit_start = en & (ph_cnt_r == {PH_W{1'b0}});
    assign bit_end   = en & (ph_cnt_r == PH_LAST);

endmodule

// File: rtl/cfg_serial_master.sv
`timescale 1ns/1ps
// cfg_serial_master: serial configuration master.
// Holds NUM_WORDS configuration words, resets the target, shifts the bank out
// MSB-first (word 0 first) on sclk/sdout, then waits for target ready with a
// timeout and a bounded number of re-reset/re-send retries.
//   i_clk, i_resetbALL : clock, asynchronous active-low reset
//   i_start            : one-cycle transfer request (honoured in IDLE/ERROR)
//   i_wr_en/addr/data  : bank write port (ignored while busy)
//   i_ready            : asynchronous target ready, 2-flop synchronised
//   o_resetb_target    : active-low target reset
//   o_sclk, o_sdout    : registered serial clock / data
//   o_busy, o_done     : transfer in progress / one-cycle success pulse
//   o_error            : sticky failure flag, o_retry_cnt: retries used
module cfg_serial_master
    import cfg_serial_pkg::*;
#(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned NUM_WORDS   = 4,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned SCLK_DIV    = 2,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned RDY_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned RETRY_W     = 2
) (
    input  logic               i_clk,
    input  logic               i_resetbALL,
    input  logic               i_start,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [WORD_W-1:0]  i_wr_data,
    input  logic               i_ready,
    output logic               o_resetb_target,
    output logic               o_sclk,
    output logic               o_sdout,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [RETRY_W-1:0] o_retry_cnt
);
    // One timer serves both the reset hold and the ready timeout.
    localparam int unsigned        TMR_MAX   = (RST_HOLD > RDY_TIMEOUT) ? RST_HOLD : RDY_TIMEOUT;
    localparam int unsigned        TMR_W     = clog2_min1(TMR_MAX);
    localparam logic [TMR_W-1:0]   HOLD_LAST = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0]   TMO_LAST  = TMR_W'(RDY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
    localparam int unsigned        WIDX_W    = clog2_min1(NUM_WORDS);
    localparam int unsigned        BIDX_W    = clog2_min1(WORD_W);
    localparam logic [WIDX_W-1:0]  WORD_LAST = WIDX_W'(NUM_WORDS - 1);
    localparam logic [WIDX_W-1:0]  WIDX_ONE  = WIDX_W'(1);
    localparam logic [BIDX_W-1:0]  BIT_TOP   = BIDX_W'(WORD_W - 1);
    localparam logic [BIDX_W-1:0]  BIDX_ONE  = BIDX_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

    logic [2:0]         state_r;
    logic [2:0]         next_state_s;
    logic [TMR_W-1:0]   tmr_r;
    logic [WIDX_W-1:0]  word_idx_r;
    logic [BIDX_W-1:0]  bit_idx_r;
    logic [WORD_W-1:0]  bank_r [NUM_WORDS];
    logic               rdy_meta_r;
    logic               rdy_sync_r;
    logic [RETRY_W-1:0] retry_r;
    logic               resetb_r;
    logic               sdout_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic               sclk_s;
    logic               bit_start_s;
    logic               bit_end_s;
    logic               shift_en_s;
    logic               busy_st_s;
    logic               start_ok_s;
    logic               last_bit_s;
    logic               cur_bit_s;

    assign shift_en_s = (state_r == ST_SHIFT);
    assign busy_st_s  = (state_r == ST_RST_TGT) | (state_r == ST_SHIFT) | (state_r == ST_WAIT_RDY);
    assign start_ok_s = i_start & ((state_r == ST_IDLE) | (state_r == ST_ERROR));
    assign last_bit_s = (word_idx_r == WORD_LAST) & (bit_idx_r == {BIDX_W{1'b0}});
    assign cur_bit_s  = bank_r[word_idx_r][bit_idx_r];

    cfg_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk       (i_clk),
        .rst_n     (i_resetbALL),
        .en        (shift_en_s),
        .sclk      (sclk_s),
        .bit_start (bit_start_s),
        .bit_end   (bit_end_s)
    );

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) next_state_s = ST_RST_TGT;
                else         next_state_s = ST_IDLE;
            end
            ST_RST_TGT: begin
                if (tmr_r == HOLD_LAST) next_state_s = ST_SHIFT;
                else                    next_state_s = ST_RST_TGT;
            end
            ST_SHIFT: begin
                if (bit_end_s && last_bit_s) next_state_s = ST_WAIT_RDY;
                else                         next_state_s = ST_SHIFT;
            end
            ST_WAIT_RDY: begin
                if (rdy_sync_r) begin
                    next_state_s = ST_DONE;
                end else if (tmr_r == TMO_LAST) begin
                    if (retry_r < RETRY_MAX) next_state_s = ST_RST_TGT;
                    else                     next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_WAIT_RDY;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERROR: begin
                if (i_start) next_state_s = ST_RST_TGT;
                else         next_state_s = ST_ERROR;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) state_r <= ST_IDLE;
        else              state_r <= next_state_s;
    end

    // Hold/timeout timer: restarts on every state change.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if (next_state_s != state_r) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if ((state_r == ST_RST_TGT) || (state_r == ST_WAIT_RDY)) begin
            tmr_r <= tmr_r + TMR_ONE;
        end else begin
            tmr_r <= {TMR_W{1'b0}};
        end
    end

    // Configuration bank; frozen while busy, out-of-range addresses match no word.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            for (int i = 0; i < NUM_WORDS; i++) bank_r[i] <= {WORD_W{1'b0}};
        end else if (i_wr_en && !busy_st_s) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (i_wr_addr == ADDR_W'(i)) bank_r[i] <= i_wr_data;
                else                         bank_r[i] <= bank_r[i];
            end
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) bank_r[i] <= bank_r[i];
        end
    end

    // Word/bit pointers: word 0 MSB first, advanced at the end of each bit.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            word_idx_r <= {WIDX_W{1'b0}};
            bit_idx_r  <= BIT_TOP;
        end else if (!shift_en_s) begin
            word_idx_r <= {WIDX_W{1'b0}};
            bit_idx_r  <= BIT_TOP;
        end else if (bit_end_s) begin
            if (bit_idx_r == {BIDX_W{1'b0}}) begin
                word_idx_r <= word_idx_r + WIDX_ONE;
                bit_idx_r  <= BIT_TOP;
            end else begin
                word_idx_r <= word_idx_r;
                bit_idx_r  <= bit_idx_r - BIDX_ONE;
            end
        end else begin
            word_idx_r <= word_idx_r;
            bit_idx_r  <= bit_idx_r;
        end
    end

    // Two-flop synchroniser for the asynchronous target ready.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            rdy_meta_r <= 1'b0;
            rdy_sync_r <= 1'b0;
        end else begin
            rdy_meta_r <= i_ready;
            rdy_sync_r <= rdy_meta_r;
        end
    end

    // Retry counter: cleared by an accepted start, bumped on each timeout retry.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            retry_r <= {RETRY_W{1'b0}};
        end else if (start_ok_s) begin
            retry_r <= {RETRY_W{1'b0}};
        end else if ((state_r == ST_WAIT_RDY) && (next_state_s == ST_RST_TGT)) begin
            retry_r <= retry_r + RETRY_ONE;
        end else begin
            retry_r <= retry_r;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            resetb_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            resetb_r <= !((next_state_s == ST_RST_TGT) || (next_state_s == ST_ERROR));
            busy_r   <= (next_state_s == ST_RST_TGT) || (next_state_s == ST_SHIFT) ||
                        (next_state_s == ST_WAIT_RDY);
            done_r   <= (next_state_s == ST_DONE);
            error_r  <= (next_state_s == ST_ERROR);
        end
    end

    // Serial data: loaded only as a low phase begins, forced low outside SHIFT.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            sdout_r <= 1'b0;
        end else if (!shift_en_s) begin
            sdout_r <= 1'b0;
        end else if (bit_start_s) begin
            sdout_r <= cur_bit_s;
        end else begin
            sdout_r <= sdout_r;
        end
    end

    assign o_resetb_target = resetb_r;
    assign o_sclk          = sclk_s;
    assign o_sdout         = sdout_r;
    assign o_busy          = busy_r;
    assign o_done          = done_r;
    assign o_error         = error_r;
    assign o_retry_cnt     = retry_r;

endmodule

// File: tb/tb_cfg_serial_master.sv
`timescale 1ns/1ps
// tb_cfg_serial_master: scoreboard bench. Each accepted start pushes the
// expected 32-bit frame(s); a negedge monitor rebuilds frames from sdout at
// sclk rises and pops/compares them. Cycle positions are measured from the
// sample just after the edge that takes i_start (k = 0).
module tb_cfg_serial_master;
    localparam int unsigned SCLK_DIV = 3;

    logic       clk, rst_n, start, wr_en, ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       resetb_tgt, sclk, sdout, busy, done, error;
    logic [1:0] retry_cnt;

    int         err_cnt, chk_cnt;
    logic [7:0] model_bank [4];
    logic [31:0] exp_q [$];

    cfg_serial_master #(
        .WORD_W(8), .NUM_WORDS(4), .ADDR_W(2), .SCLK_DIV(SCLK_DIV), .RST_HOLD(16),
        .RDY_TIMEOUT(64), .MAX_RETRY(2), .RETRY_W(2)
    ) dut (
        .i_clk(clk), .i_resetbALL(rst_n), .i_start(start), .i_wr_en(wr_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_ready(ready),
        .o_resetb_target(resetb_tgt), .o_sclk(sclk), .o_sdout(sdout), .o_busy(busy),
        .o_done(done), .o_error(error), .o_retry_cnt(retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: frame capture, sclk phase widths, sdout stability, done pulses.
    logic        prev_sclk, prev_sdout;
    logic [31:0] cap;
    int          run_len, cap_n, width_bad, stable_bad, done_cnt, last_hi, last_lo;
    always @(negedge clk) begin
        if (!rst_n) begin
            cap_n = 0; run_len = 0; prev_sclk = 1'b0; prev_sdout = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (sclk && prev_sclk && (sdout !== prev_sdout)) stable_bad++;
            if (sclk != prev_sclk) begin
                if (prev_sclk) begin
                    last_hi = run_len;
                    if (run_len != SCLK_DIV) width_bad++;
                end else begin
                    if (cap_n > 0) begin
                        last_lo = run_len;
                        if (run_len != SCLK_DIV) width_bad++;
                    end
                    cap = {cap[30:0], sdout};
                    cap_n++;
                    if (cap_n == 32) begin
                        if (exp_q.size() == 0) check_eq("frame_unexpected", 32'd0, 32'd1);
                        else                   check_eq("frame", cap, exp_q.pop_front());
                        cap_n = 0;
                    end
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_sclk = sclk; prev_sdout = sdout;
        end
    end

    function automatic logic [31:0] frame_of();
        return {model_bank[0], model_bank[1], model_bank[2], model_bank[3]};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d; model_bank[a] = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    // Start pulse (optionally with a same-cycle write); returns at sample k=0.
    task automatic kick(input bit do_wr, input logic [1:0] a, input logic [7:0] d, input int n_frames);
        @(negedge clk);
        start = 1'b1;
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d; model_bank[a] = d;
        end
        for (int i = 0; i < n_frames; i++) exp_q.push_back(frame_of());
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
    endtask

    // Bounded observation until done or error; -1 means never seen.
    task automatic watch(input int budget, input logic rb_init, output int rst_lo, output int rise_at,
                         output int done_at, output int err_at, output int attempts);
        logic prev_rb;
        prev_rb = rb_init; rst_lo = 0; rise_at = -1; done_at = -1; err_at = -1; attempts = 0;
        for (int k = 0; k < budget; k++) begin
            if (error) begin err_at = k; break; end
            if (!resetb_tgt) rst_lo++;
            if (prev_rb && !resetb_tgt) attempts++;
            prev_rb = resetb_tgt;
            if (sclk && (rise_at < 0)) rise_at = k;
            if (done) begin done_at = k; break; end
            @(negedge clk);
        end
    endtask

    int lo, rise, dn, er, att, d0;

    initial begin
        rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; ready = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
        for (int i = 0; i < 4; i++) model_bank[i] = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {24'd0, resetb_tgt, sclk, sdout, busy, done, error, retry_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_resetb", resetb_tgt, 32'd1);

        // Basic transfer, ready already high.
        wr(2'd0, 8'hA5); wr(2'd1, 8'h3C); wr(2'd2, 8'hFF); wr(2'd3, 8'h01);
        ready = 1'b1;
        kick(1'b0, 2'd0, 8'd0, 1);
        check_eq("t1_busy", busy, 32'd1);
        watch(400, 1'b1, lo, rise, dn, er, att);
        check_eq("t1_rst_low", lo, 32'd16);
        check_eq("t1_first_rise", rise, 32'd20);
        check_eq("t1_done_at", dn, 32'd209);
        check_eq("t1_retry", retry_cnt, 32'd0);
        @(negedge clk);
        check_eq("t1_done_pulse", {busy, done}, 32'd0);
        check_eq("t1_sclk_hi", last_hi, SCLK_DIV);
        check_eq("t1_sclk_lo", last_lo, SCLK_DIV);

        // Ready never comes: three attempts then error.
        ready = 1'b0; d0 = done_cnt;
        kick(1'b0, 2'd0, 8'd0, 3);
        watch(1000, 1'b1, lo, rise, dn, er, att);
        check_eq("t3_err_at", er, 32'd816);
        check_eq("t3_attempts", att, 32'd3);
        check_eq("t3_rst_low", lo, 32'd48);
        check_eq("t3_retry", retry_cnt, 32'd2);
        check_eq("t3_flags", {resetb_tgt, busy, error}, 32'b001);
        check_eq("t3_no_done", done_cnt, d0);
        ready = 1'b1;
        kick(1'b0, 2'd0, 8'd0, 1);
        check_eq("t3_restart", {error, busy, retry_cnt}, 32'b0100);
        watch(400, 1'b0, lo, rise, dn, er, att);
        check_eq("t3_restart_done", dn, 32'd209);

        // Ready arrives during the second wait window.
        ready = 1'b0;
        kick(1'b0, 2'd0, 8'd0, 2);
        repeat (500) @(negedge clk);
        ready = 1'b1;
        watch(100, 1'b1, lo, rise, dn, er, att);
        check_eq("t4_done_lat", dn, 32'd3);
        check_eq("t4_retry", retry_cnt, 32'd1);
        check_eq("t4_error", error, 32'd0);

        // Write and start while shifting are ignored; write+start in IDLE is honoured.
        kick(1'b0, 2'd0, 8'd0, 1);
        repeat (60) @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h77; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        watch(300, 1'b1, lo, rise, dn, er, att);
        check_eq("t5_done_at", dn, 32'd148);
        repeat (5) @(negedge clk);
        check_eq("t5_no_restart", busy, 32'd0);
        kick(1'b1, 2'd3, 8'h5A, 1);
        watch(400, 1'b1, lo, rise, dn, er, att);
        check_eq("t5_wr_start_done", dn, 32'd209);

        // Asynchronous reset mid-shift clears everything, including the bank.
        kick(1'b0, 2'd0, 8'd0, 1);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("t6_rst_outs", {24'd0, resetb_tgt, sclk, sdout, busy, done, error, retry_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) model_bank[i] = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_busy", busy, 32'd0);
        kick(1'b0, 2'd0, 8'd0, 1);
        watch(400, 1'b1, lo, rise, dn, er, att);
        check_eq("t6_done_at", dn, 32'd209);

        repeat (5) @(negedge clk);
        check_eq("sb_drain", exp_q.size(), 32'd0);
        check_eq("sdout_stable", stable_bad, 32'd0);
        check_eq("sclk_width", width_bad, 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        err_cnt++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
